// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle data-memory controller behind the MEM stage.
// It models a word-organised RAM with programmable wait states and byte, half and word
// access. It returns load data with a one-cycle mem_ready pulse, and it rejects faulty
// requests through mem_fault.
//
// Ports
//   clk         clock, all state updates on posedge
//   rst         synchronous active-high reset
//   MemRead     load request strobe, held until mem_ready seen
//   MemWrite    store request strobe, held until mem_ready seen
//   funct3      access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   dAddress    byte address
//   dWriteData  store data, low bits used for B/H
//   dReadData   load result, extended per funct3 (registered)
//   mem_ready   one-cycle completion pulse (registered)
//   mem_fault   valid with mem_ready: access rejected (registered)
module data_mem_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic        mem_ready,
  output logic        mem_fault
);

  localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SpanBytes = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WaitInit  = 4'(WAIT_CYCLES);
  localparam bit          NoWait    = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_t;

  state_t      stateQ;
  logic [3:0]  cntQ;
  logic [31:0] addrQ;
  logic [31:0] dataQ;
  logic [2:0]  f3Q;
  logic        rdQ;
  logic        wrQ;
  logic        faultQ;

  logic [31:0] ram [DEPTH_WORDS];

  logic            accept;
  logic            enterDone;
  logic [31:0]     reqAddr;
  logic [31:0]     reqData;
  logic [2:0]      reqF3;
  logic            reqRd;
  logic            reqWr;
  logic [31:0]     offset;
  logic [IdxW-1:0] wordIdx;
  logic [1:0]      lane;
  logic            faultHit;
  logic [31:0]     ramWord;
  logic [7:0]      selByte;
  logic [15:0]     selHalf;
  logic [31:0]     loadData;
  logic [31:0]     writeWord;
  logic [3:0]      byteEn;

  // Accept is held off while mem_ready is high: the requester still drives its strobes
  // during that cycle and drops them on the edge that ends it.
  assign accept = (stateQ == StIdle) && (MemRead || MemWrite) && !mem_ready;

  // Entry to DONE either straight from IDLE (zero wait states) or from the last wait cycle.
  assign enterDone = (NoWait && accept) || ((stateQ == StWait) && (cntQ == 4'd1));

  // With zero wait states, DONE is entered on the accept edge. In that case the request
  // is taken from the live inputs instead of the capture registers.
  always_comb begin
    if (stateQ == StIdle) begin
      reqAddr = dAddress;
      reqData = dWriteData;
      reqF3   = funct3;
      reqRd   = MemRead;
      reqWr   = MemWrite;
    end else begin
      reqAddr = addrQ;
      reqData = dataQ;
      reqF3   = f3Q;
      reqRd   = rdQ;
      reqWr   = wrQ;
    end
  end

  assign offset  = reqAddr - BASE_ADDR;
  assign wordIdx = offset[IdxW+1:2];
  assign lane    = reqAddr[1:0];
  assign ramWord = ram[wordIdx];

  always_comb begin
    faultHit = 1'b0;
    if (reqRd && reqWr)                                 faultHit = 1'b1;
    if (offset >= SpanBytes)                            faultHit = 1'b1;
    if ((reqF3[1:0] == 2'b01) && lane[0])               faultHit = 1'b1;
    if ((reqF3 == 3'b010) && (lane != 2'b00))           faultHit = 1'b1;
    if ((reqF3 == 3'b011) || (reqF3[2:1] == 2'b11))     faultHit = 1'b1;
    if (reqWr && (reqF3[2:1] == 2'b10))                 faultHit = 1'b1;
  end

  always_comb begin
    selByte = ramWord[8*lane +: 8];
    selHalf = lane[1] ? ramWord[31:16] : ramWord[15:0];
    unique case (reqF3)
      3'b000:  loadData = {{24{selByte[7]}}, selByte};
      3'b001:  loadData = {{16{selHalf[15]}}, selHalf};
      3'b010:  loadData = ramWord;
      3'b100:  loadData = {24'd0, selByte};
      3'b101:  loadData = {16'd0, selHalf};
      default: loadData = 32'd0;
    endcase
  end

  // Store data is replicated across lanes so that the byte enables alone pick the target.
  always_comb begin
    unique case (reqF3[1:0])
      2'b00: begin
        writeWord = {4{reqData[7:0]}};
        byteEn    = 4'b0001 << lane;
      end
      2'b01: begin
        writeWord = {2{reqData[15:0]}};
        byteEn    = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        writeWord = reqData;
        byteEn    = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= StIdle;
      cntQ      <= 4'd0;
      addrQ     <= 32'd0;
      dataQ     <= 32'd0;
      f3Q       <= 3'd0;
      rdQ       <= 1'b0;
      wrQ       <= 1'b0;
      faultQ    <= 1'b0;
      dReadData <= 32'd0;
      mem_ready <= 1'b0;
      mem_fault <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_fault <= 1'b0;

      if (enterDone) begin
        faultQ <= faultHit;
        if (faultHit) begin
          dReadData <= 32'd0;
        end else if (reqRd) begin
          dReadData <= loadData;
        end
      end

      unique case (stateQ)
        StIdle: begin
          if (accept) begin
            addrQ  <= dAddress;
            dataQ  <= dWriteData;
            f3Q    <= funct3;
            rdQ    <= MemRead;
            wrQ    <= MemWrite;
            cntQ   <= WaitInit;
            stateQ <= NoWait ? StDone : StWait;
          end
        end
        StWait: begin
          cntQ <= cntQ - 4'd1;
          if (cntQ == 4'd1) begin
            stateQ <= StDone;
          end
        end
        StDone: begin
          mem_ready <= 1'b1;
          mem_fault <= faultQ;
          stateQ    <= StIdle;
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

  // RAM is not reset. A store is committed only on an un-reset entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst && enterDone && reqWr && !faultHit) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) begin
          ram[wordIdx][8*b +: 8] <= writeWord[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  localparam logic [2:0] FB  = 3'b000;
  localparam logic [2:0] FH  = 3'b001;
  localparam logic [2:0] FW  = 3'b010;
  localparam logic [2:0] FBU = 3'b100;
  localparam logic [2:0] FHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdA, wrA, rdB, wrB;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic [31:0] rdataA, rdataB;
  logic        readyA, readyB, faultA, faultB;
  logic        sel;  // 0: two-wait-state instance, 1: zero-wait-state instance

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.BASE_ADDR(32'h10010000), .DEPTH_WORDS(512), .WAIT_CYCLES(2)) dutA (
    .clk(clk), .rst(rst), .MemRead(rdA), .MemWrite(wrA), .funct3(f3), .dAddress(addr),
    .dWriteData(wdata), .dReadData(rdataA), .mem_ready(readyA), .mem_fault(faultA)
  );

  data_mem_ctrl #(.BASE_ADDR(32'h10010000), .DEPTH_WORDS(512), .WAIT_CYCLES(0)) dutB (
    .clk(clk), .rst(rst), .MemRead(rdB), .MemWrite(wrB), .funct3(f3), .dAddress(addr),
    .dWriteData(wdata), .dReadData(rdataB), .mem_ready(readyB), .mem_fault(faultB)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request, strobes held until the edge ending mem_ready. Returns the latency from the
  // accept edge (0 = timed out), the data and fault seen with mem_ready, and the number of
  // extra mem_ready pulses in a short window afterwards.
  task automatic access(input logic rd, input logic wr, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] d, output int lat,
                        output logic [31:0] rdata, output logic fault, output int extra);
    @(negedge clk);
    f3 = fn; addr = a; wdata = d;
    if (sel) begin rdB = rd; wrB = wr; end
    else     begin rdA = rd; wrA = wr; end
    @(posedge clk);
    lat = 0; rdata = 32'd0; fault = 1'b0; extra = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (sel ? readyB : readyA) begin
        lat   = c;
        rdata = sel ? rdataB : rdataA;
        fault = sel ? faultB : faultA;
        break;
      end
    end
    @(posedge clk); #1;
    rdA = 1'b0; wrA = 1'b0; rdB = 1'b0; wrB = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (sel ? readyB : readyA) extra++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, ex, pulses;
    logic [31:0] rv;
    logic        fl;

    rst = 1'b1; rdA = 1'b0; wrA = 1'b0; rdB = 1'b0; wrB = 1'b0;
    f3 = FW; addr = 32'd0; wdata = 32'd0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ready", 32'(readyA), 32'd0);
    check_eq("reset_fault", 32'(faultA), 32'd0);
    check_eq("reset_rdata", rdataA, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: word store/load, latency WAIT_CYCLES+1
    access(1'b0, 1'b1, FW, 32'h10010004, 32'hDEADBEEF, lat, rv, fl, ex);
    check_eq("sw_latency", 32'(lat), 32'd3);
    check_eq("sw_fault", 32'(fl), 32'd0);
    access(1'b1, 1'b0, FW, 32'h10010004, 32'd0, lat, rv, fl, ex);
    check_eq("lw_latency", 32'(lat), 32'd3);
    check_eq("lw_data", rv, 32'hDEADBEEF);
    check_eq("lw_fault", 32'(fl), 32'd0);
    check_eq("lw_single_pulse", 32'(ex), 32'd0);

    // 2: byte store, signed/unsigned byte loads
    access(1'b0, 1'b1, FB, 32'h10010005, 32'h00000080, lat, rv, fl, ex);
    check_eq("sb_keeps_rdata", rdataA, 32'hDEADBEEF);
    access(1'b1, 1'b0, FB, 32'h10010005, 32'd0, lat, rv, fl, ex);
    check_eq("lb_data", rv, 32'hFFFFFF80);
    access(1'b1, 1'b0, FBU, 32'h10010005, 32'd0, lat, rv, fl, ex);
    check_eq("lbu_data", rv, 32'h00000080);
    access(1'b1, 1'b0, FW, 32'h10010004, 32'd0, lat, rv, fl, ex);
    check_eq("lw_after_sb", rv, 32'hDEAD80EF);

    // 3: half store into upper lanes
    access(1'b0, 1'b1, FH, 32'h10010006, 32'hFFFF1234, lat, rv, fl, ex);
    access(1'b1, 1'b0, FW, 32'h10010004, 32'd0, lat, rv, fl, ex);
    check_eq("lw_after_sh", rv, 32'h123480EF);
    access(1'b1, 1'b0, FHU, 32'h10010006, 32'd0, lat, rv, fl, ex);
    check_eq("lhu_data", rv, 32'h00001234);
    access(1'b1, 1'b0, FH, 32'h10010004, 32'd0, lat, rv, fl, ex);
    check_eq("lh_neg_data", rv, 32'hFFFF80EF);

    // 4: faults
    access(1'b1, 1'b0, FW, 32'h10010002, 32'd0, lat, rv, fl, ex);
    check_eq("misalign_w_fault", 32'(fl), 32'd1);
    check_eq("misalign_w_rdata", rv, 32'd0);
    access(1'b1, 1'b0, FH, 32'h10010001, 32'd0, lat, rv, fl, ex);
    check_eq("misalign_h_fault", 32'(fl), 32'd1);
    access(1'b1, 1'b0, FW, 32'h10010800, 32'd0, lat, rv, fl, ex);
    check_eq("oob_high_fault", 32'(fl), 32'd1);
    check_eq("oob_high_latency", 32'(lat), 32'd3);
    access(1'b1, 1'b0, FW, 32'h0FFFFFFC, 32'd0, lat, rv, fl, ex);
    check_eq("oob_low_fault", 32'(fl), 32'd1);
    access(1'b1, 1'b1, FW, 32'h10010004, 32'hFFFFFFFF, lat, rv, fl, ex);
    check_eq("rw_conflict_fault", 32'(fl), 32'd1);
    check_eq("rw_conflict_rdata", rv, 32'd0);
    access(1'b1, 1'b0, 3'b011, 32'h10010004, 32'd0, lat, rv, fl, ex);
    check_eq("illegal_f3_fault", 32'(fl), 32'd1);
    access(1'b0, 1'b1, FBU, 32'h10010004, 32'h000000AA, lat, rv, fl, ex);
    check_eq("store_bu_fault", 32'(fl), 32'd1);
    access(1'b1, 1'b0, FW, 32'h10010004, 32'd0, lat, rv, fl, ex);
    check_eq("post_fault_lw", rv, 32'h123480EF);
    check_eq("post_fault_nofault", 32'(fl), 32'd0);

    // Last in-range word
    access(1'b0, 1'b1, FW, 32'h100107FC, 32'hCAFEF00D, lat, rv, fl, ex);
    check_eq("last_word_sw_fault", 32'(fl), 32'd0);
    access(1'b1, 1'b0, FW, 32'h100107FC, 32'd0, lat, rv, fl, ex);
    check_eq("last_word_lw", rv, 32'hCAFEF00D);

    // 5: reset during WAIT aborts the store
    access(1'b0, 1'b1, FW, 32'h10010008, 32'd0, lat, rv, fl, ex);
    @(negedge clk);
    f3 = FW; addr = 32'h10010008; wdata = 32'h00000055; wrA = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; wrA = 1'b0;
    pulses = 0;
    @(posedge clk); #1;
    if (readyA) pulses++;
    check_eq("midreset_rdata", rdataA, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (readyA) pulses++;
    end
    check_eq("midreset_no_ready", 32'(pulses), 32'd0);
    access(1'b1, 1'b0, FW, 32'h10010008, 32'd0, lat, rv, fl, ex);
    check_eq("midreset_not_committed", rv, 32'd0);
    check_eq("midreset_recover_lat", 32'(lat), 32'd3);

    // 6: zero-wait-state instance
    sel = 1'b1;
    access(1'b0, 1'b1, FW, 32'h10010010, 32'h11223344, lat, rv, fl, ex);
    check_eq("nowait_sw_latency", 32'(lat), 32'd1);
    check_eq("nowait_sw_single_pulse", 32'(ex), 32'd0);
    access(1'b1, 1'b0, FW, 32'h10010010, 32'd0, lat, rv, fl, ex);
    check_eq("nowait_lw_latency", 32'(lat), 32'd1);
    check_eq("nowait_lw_data", rv, 32'h11223344);
    check_eq("nowait_lw_single_pulse", 32'(ex), 32'd0);
    access(1'b1, 1'b0, FB, 32'h10010013, 32'd0, lat, rv, fl, ex);
    check_eq("nowait_lb_data", rv, 32'h00000011);
    access(1'b1, 1'b0, FW, 32'h10010011, 32'd0, lat, rv, fl, ex);
    check_eq("nowait_misalign_fault", 32'(fl), 32'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
